// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared state encoding and ratio constants for the clock divider config path
package clkdiv_pkg;

  localparam int CLKDIV_WIDTH  = 4;
  localparam int RATIO_ILLEGAL = 0;
  localparam int RATIO_BYPASS  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    LOAD   = 2'd2,
    SETTLE = 2'd3
  } clkdiv_state_e;

endpackage

// File: rtl/clkdiv_cfg_ctrl_if.sv
// rtl/clkdiv_cfg_ctrl_if.sv - config handshake and divider control bundle (optional CLKDIV_CFG_STATUS_EN counters)
interface clkdiv_cfg_ctrl_if
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = CLKDIV_WIDTH
);

  logic             i_run_en;
  logic             i_cfg_valid;
  logic [WIDTH-1:0] i_cfg_ratio;
  logic             o_cfg_ready;
  logic [WIDTH-1:0] o_div_ratio;
  logic             o_clk_en;
  logic             o_busy;
  logic             o_cfg_err;
`ifdef CLKDIV_CFG_STATUS_EN
  logic [7:0]       o_upd_cnt;
  logic [7:0]       o_err_cnt;

  modport master (
    output i_run_en, i_cfg_valid, i_cfg_ratio,
    input  o_cfg_ready, o_div_ratio, o_clk_en, o_busy, o_cfg_err, o_upd_cnt, o_err_cnt
  );

  modport slave (
    input  i_run_en, i_cfg_valid, i_cfg_ratio,
    output o_cfg_ready, o_div_ratio, o_clk_en, o_busy, o_cfg_err, o_upd_cnt, o_err_cnt
  );
`else
  modport master (
    output i_run_en, i_cfg_valid, i_cfg_ratio,
    input  o_cfg_ready, o_div_ratio, o_clk_en, o_busy, o_cfg_err
  );

  modport slave (
    input  i_run_en, i_cfg_valid, i_cfg_ratio,
    output o_cfg_ready, o_div_ratio, o_clk_en, o_busy, o_cfg_err
  );
`endif

endinterface

// File: rtl/clkdiv_settle_cnt.sv
// rtl/clkdiv_settle_cnt.sv - load/count/done counter timing the DRAIN and SETTLE windows
module clkdiv_settle_cnt #(
  parameter int CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_done
);

  localparam int            CW   = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear on load, otherwise advance while the window is open.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Done on the last cycle of the window so the FSM leaves exactly CYCLES cycles after entry.
  assign o_done = i_en && (cnt_q == LAST);

endmodule

// File: rtl/clkdiv_cfg_ctrl.sv
// rtl/clkdiv_cfg_ctrl.sv - glitch-free ratio/enable sequencer for the integer divider (optional CLKDIV_CFG_STATUS_EN)
module clkdiv_cfg_ctrl
  import clkdiv_pkg::*;
#(
  parameter int WIDTH         = CLKDIV_WIDTH,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEFAULT_RATIO = 1
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  clkdiv_cfg_ctrl_if.slave cfg_if
);

  localparam logic [WIDTH-1:0] RATIO_ZERO = WIDTH'(RATIO_ILLEGAL);
  localparam logic [WIDTH-1:0] RATIO_ONE  = WIDTH'(RATIO_BYPASS);
  localparam logic [WIDTH-1:0] RATIO_RST  = WIDTH'(DEFAULT_RATIO);

  clkdiv_state_e    state_q;
  clkdiv_state_e    state_d;
  logic [WIDTH-1:0] ratio_q;
  logic [WIDTH-1:0] ratio_d;
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] pend_d;
  logic             clk_en_q;
  logic             clk_en_d;
  logic             err_q;
  logic             err_d;

  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_done;

  logic             req_take;
  logic             req_bad;
  logic             req_same;

  assign req_take = (state_q == IDLE) && cfg_if.i_cfg_valid;
  assign req_bad  = req_take && (cfg_if.i_cfg_ratio == RATIO_ZERO);
  assign req_same = (cfg_if.i_cfg_ratio == ratio_q);

  clkdiv_settle_cnt #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle_cnt (
    .i_clk   (i_ref_clk),
    .i_rst_n (i_rst_n),
    .i_load  (cnt_load),
    .i_en    (cnt_en),
    .o_done  (cnt_done)
  );

  // Next-state, ratio staging and enable decision; enable only returns once back in IDLE.
  always_comb begin
    state_d  = state_q;
    ratio_d  = ratio_q;
    pend_d   = pend_q;
    err_d    = req_bad;
    cnt_load = 1'b1;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_take && !req_bad && !req_same) begin
          pend_d  = cfg_if.i_cfg_ratio;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_load = 1'b0;
        cnt_en   = 1'b1;
        if (cnt_done) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        ratio_d = pend_q;
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_load = 1'b0;
        cnt_en   = 1'b1;
        if (cnt_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Ratio 1 means the divider bypasses to the ref clock, so it is never enabled.
    clk_en_d = cfg_if.i_run_en && (state_d == IDLE) && (ratio_d != RATIO_ONE);
  end

  // State and output registers; reset drops any pending ratio.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ratio_q  <= RATIO_RST;
      pend_q   <= RATIO_RST;
      clk_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ratio_q  <= ratio_d;
      pend_q   <= pend_d;
      clk_en_q <= clk_en_d;
      err_q    <= err_d;
    end
  end

  assign cfg_if.o_cfg_ready = (state_q == IDLE);
  assign cfg_if.o_busy      = (state_q != IDLE);
  assign cfg_if.o_div_ratio = ratio_q;
  assign cfg_if.o_clk_en    = clk_en_q;
  assign cfg_if.o_cfg_err   = err_q;

`ifdef CLKDIV_CFG_STATUS_EN
  logic       upd_evt;
  logic [7:0] upd_cnt_q;
  logic [7:0] upd_cnt_d;
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  assign upd_evt = (state_q == SETTLE) && cnt_done;

  // Saturating event counters for completed updates and rejected requests.
  always_comb begin
    upd_cnt_d = upd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (upd_evt && (upd_cnt_q != 8'hFF)) begin
      upd_cnt_d = upd_cnt_q + 8'd1;
    end
    if (req_bad && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Status counter registers.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      upd_cnt_q <= 8'd0;
      err_cnt_q <= 8'd0;
    end else begin
      upd_cnt_q <= upd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cfg_if.o_upd_cnt = upd_cnt_q;
  assign cfg_if.o_err_cnt = err_cnt_q;
`endif

endmodule
